// File: rtl/synth_pkg.sv
// Shared definitions for the button/switch square-wave synthesizer.
//   note_t       : 3-bit note code (0 = rest, 1..7 = C4..C5)
//   HALF_PERIOD  : half-period in clock cycles for each note code
//   SEQ_ROM      : fixed 16-step tune that the sequencer plays
//   BUTTON_NOTE  : note assigned to each live-mode button
//   live_note()  : priority encoder from buttons to a note code
package synth_pkg;

  localparam int PC_WIDTH_DEF = 4;
  localparam int HP_W         = 17;

  typedef enum logic [2:0] {
    NOTE_REST = 3'd0,
    NOTE_C4   = 3'd1,
    NOTE_D4   = 3'd2,
    NOTE_E4   = 3'd3,
    NOTE_F4   = 3'd4,
    NOTE_G4   = 3'd5,
    NOTE_A4   = 3'd6,
    NOTE_C5   = 3'd7
  } note_t;

  // Half-periods at the unshifted octave (50 MHz clock).
  localparam logic [HP_W-1:0] HALF_PERIOD [8] = '{
    17'd0,     17'd95556, 17'd85131, 17'd75843,
    17'd71586, 17'd63776, 17'd56818, 17'd47778
  };

  localparam note_t SEQ_ROM [16] = '{
    NOTE_C4, NOTE_E4, NOTE_G4, NOTE_C5, NOTE_G4, NOTE_E4, NOTE_C4, NOTE_REST,
    NOTE_C4, NOTE_C4, NOTE_G4, NOTE_G4, NOTE_A4, NOTE_A4, NOTE_G4, NOTE_REST
  };

  localparam note_t BUTTON_NOTE [4] = '{NOTE_C4, NOTE_E4, NOTE_G4, NOTE_C5};

  // Scan from the top button down so the lowest pressed index wins.
  function automatic note_t live_note(input logic [3:0] b);
    note_t n;
    n = NOTE_REST;
    for (int i = 3; i >= 0; i--) begin
      if (b[i]) n = BUTTON_NOTE[i];
    end
    return n;
  endfunction

endpackage

// File: rtl/synth_if.sv
// Board-side bus of the synthesizer.
//   buttons      : note buttons, active high
//   Sw           : [2:0] octave shift, [3] sound enable, [7:4] tempo,
//                  [8] unused, [9] mode (0 live, 1 sequencer)
//   Output_Sound : registered square-wave audio
//   dbg_pc, dbg_code, dbg_pc_en : sequencer PC, current note code and
//                  one-cycle step pulse, exposed for observation
// All signals are level-sampled on every rising clock edge; this bus has
// no valid/ready handshake.
interface synth_if #(parameter int PC_WIDTH = 4);
  logic [3:0]          buttons;
  logic [9:0]          Sw;
  logic                Output_Sound;
  logic [PC_WIDTH-1:0] dbg_pc;
  logic [2:0]          dbg_code;
  logic                dbg_pc_en;

  modport master (output buttons, Sw,
                  input  Output_Sound, dbg_pc, dbg_code, dbg_pc_en);
  modport slave  (input  buttons, Sw,
                  output Output_Sound, dbg_pc, dbg_code, dbg_pc_en);
endinterface

// File: rtl/tone_gen.sv
// Square-wave tone generator. Holds the note-code register and a divider
// that toggles the output every (HALF_PERIOD[code] >> octave) cycles.
//   clock, reset : system clock, synchronous active-low reset
//   i_code       : next note code (from live buttons or sequencer ROM)
//   i_octave     : octave shift 0..7
//   i_enable     : 1 = sound allowed
//   o_sound      : registered square wave
//   o_code       : current registered note code
module tone_gen
  import synth_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  note_t      i_code,
  input  logic [2:0] i_octave,
  input  logic       i_enable,
  output logic       o_sound,
  output logic [2:0] o_code
);

  note_t           r_code;
  logic [2:0]      r_octave;
  logic [HP_W-1:0] r_count;
  logic            r_out;
  logic [HP_W-1:0] w_hp;

  assign w_hp    = HALF_PERIOD[r_code] >> r_octave;
  assign o_sound = r_out;
  assign o_code  = r_code;

  // A code or octave change restarts the wave low, so a new note always
  // begins with a full low half-period and never with a stray pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_code   <= NOTE_REST;
      r_octave <= 3'd0;
      r_count  <= '0;
      r_out    <= 1'b0;
    end else begin
      r_code   <= i_code;
      r_octave <= i_octave;
      if (i_code != r_code || i_octave != r_octave ||
          !i_enable || i_code == NOTE_REST) begin
        r_count <= '0;
        r_out   <= 1'b0;
      end else if (r_count == w_hp - 17'd1) begin
        r_count <= '0;
        r_out   <= ~r_out;
      end else begin
        r_count <= r_count + 17'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_synth_top.sv
// Top level of the FPGA synthesizer: selects a note from the buttons (live
// mode) or from a 16-step ROM walked by a tempo-timed PC (sequencer mode)
// and drives a square wave on the audio pin.
//   clock, reset : system clock, synchronous active-low reset
//   bus          : synth_if slave (buttons, Sw in; Output_Sound, debug out)
module cpu_synth_top
  import synth_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 12_500_000,
  parameter int          PC_WIDTH    = PC_WIDTH_DEF
) (
  input  logic clock,
  input  logic reset,
  synth_if.slave bus
);

  // Longest step is 16 tempo units.
  localparam int TIMER_W = $clog2(16 * STEP_CYCLES);

  logic [PC_WIDTH-1:0] r_pc;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_pc_en;
  logic [TIMER_W-1:0]  w_term;
  note_t               w_code;
  logic                w_seq_mode;
  logic                w_unused;

  assign w_seq_mode = bus.Sw[9];
  assign w_unused   = bus.Sw[8];

  // Terminal count follows the tempo switches live; the >= compare makes a
  // shortened tempo step on the next cycle if the timer is already past it.
  assign w_term = TIMER_W'((32'(bus.Sw[7:4]) + 32'd1) * STEP_CYCLES - 32'd1);

  assign w_code = w_seq_mode ? SEQ_ROM[r_pc] : live_note(bus.buttons);

  always_ff @(posedge clock) begin
    if (!reset || !w_seq_mode) begin
      r_pc    <= '0;
      r_timer <= '0;
      r_pc_en <= 1'b0;
    end else if (r_timer >= w_term) begin
      r_timer <= '0;
      r_pc    <= r_pc + PC_WIDTH'(1);
      r_pc_en <= 1'b1;
    end else begin
      r_timer <= r_timer + TIMER_W'(1);
      r_pc_en <= 1'b0;
    end
  end

  tone_gen u_tone (
    .clock    (clock),
    .reset    (reset),
    .i_code   (w_code),
    .i_octave (bus.Sw[2:0]),
    .i_enable (bus.Sw[3]),
    .o_sound  (bus.Output_Sound),
    .o_code   (bus.dbg_code)
  );

  assign bus.dbg_pc    = r_pc;
  assign bus.dbg_pc_en = r_pc_en;

endmodule

// File: tb/tb_cpu_synth_top.sv
// Directed bench for cpu_synth_top (sequencer step shortened to 8 cycles).
module tb_cpu_synth_top;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc;
  int   highs;
  int   exp_rom [16] = '{1, 3, 5, 7, 5, 3, 1, 0, 1, 1, 5, 5, 6, 6, 5, 0};

  synth_if #(.PC_WIDTH(4)) bus ();

  cpu_synth_top #(.STEP_CYCLES(8), .PC_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  function automatic logic [9:0] sw(input logic mode, input logic [3:0] tempo,
                                    input logic en, input logic [2:0] oct);
    return {mode, 1'b0, tempo, en, oct};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts edges until Output_Sound changes; gives up after 2000 edges.
  task automatic wait_toggle(output int cycles);
    logic prev;
    prev   = bus.Output_Sound;
    cycles = 0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
    end while (bus.Output_Sound === prev && cycles < 2000);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset       = 1'b0;
    bus.buttons = 4'b0001;
    bus.Sw      = sw(1'b0, 4'd0, 1'b1, 3'd7);
    tick(2);
    check("reset_out", 32'(bus.Output_Sound), 0);
    check("reset_pc", 32'(bus.dbg_pc), 0);
    check("reset_code", 32'(bus.dbg_code), 0);

    // Live C4, octave 7: half-period 746
    reset = 1'b1;
    tick(1);
    check("c4_code", 32'(bus.dbg_code), 1);
    check("c4_low_after_release", 32'(bus.Output_Sound), 0);
    wait_toggle(cyc);
    check("c4_first_half", 32'(cyc), 746);
    check("c4_high", 32'(bus.Output_Sound), 1);
    wait_toggle(cyc);
    check("c4_second_half", 32'(cyc), 746);
    check("c4_low", 32'(bus.Output_Sound), 0);
    wait_toggle(cyc);
    check("c4_third_half", 32'(cyc), 746);

    // Switch to G4 while high: restarts low, half-period 498
    bus.buttons = 4'b0100;
    tick(1);
    check("g4_code", 32'(bus.dbg_code), 5);
    check("g4_restart_low", 32'(bus.Output_Sound), 0);
    wait_toggle(cyc);
    check("g4_first_half", 32'(cyc), 498);
    wait_toggle(cyc);
    check("g4_second_half", 32'(cyc), 498);

    // Two buttons: lowest index (E4) wins, half-period 592
    bus.buttons = 4'b1010;
    tick(1);
    check("e4_priority_code", 32'(bus.dbg_code), 3);
    wait_toggle(cyc);
    check("e4_first_half", 32'(cyc), 592);
    check("e4_high", 32'(bus.Output_Sound), 1);

    // Disable: silent
    bus.Sw = sw(1'b0, 4'd0, 1'b0, 3'd7);
    tick(1);
    check("disable_drops_low", 32'(bus.Output_Sound), 0);
    highs = 0;
    for (int i = 0; i < 1300; i++) begin
      tick(1);
      if (bus.Output_Sound !== 1'b0) highs++;
    end
    check("disabled_silent", 32'(highs), 0);

    // Re-enable at octave 6: 75843 >> 6 = 1185
    bus.Sw = sw(1'b0, 4'd0, 1'b1, 3'd6);
    tick(1);
    check("e4_oct6_low", 32'(bus.Output_Sound), 0);
    wait_toggle(cyc);
    check("e4_oct6_half", 32'(cyc), 1185);
    check("e4_oct6_high", 32'(bus.Output_Sound), 1);

    // Reset while high: output drops on that edge
    reset = 1'b0;
    tick(1);
    check("live_reset_out", 32'(bus.Output_Sound), 0);
    check("live_reset_code", 32'(bus.dbg_code), 0);
    reset       = 1'b1;
    bus.buttons = 4'b0000;
    tick(2);
    check("no_button_code", 32'(bus.dbg_code), 0);
    check("no_button_out", 32'(bus.Output_Sound), 0);

    // Sequencer, tempo 0: step every 8 cycles, buttons ignored
    bus.buttons = 4'b0001;
    bus.Sw      = sw(1'b1, 4'd0, 1'b1, 3'd7);
    tick(1);
    check("seq_start_pc", 32'(bus.dbg_pc), 0);
    check("seq_start_code", 32'(bus.dbg_code), 1);
    check("seq_start_pc_en", 32'(bus.dbg_pc_en), 0);
    tick(7);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("seq_pc_%0d", i), 32'(bus.dbg_pc), 32'(i % 16));
      check($sformatf("seq_pc_en_%0d", i), 32'(bus.dbg_pc_en), 1);
      tick(1);
      check($sformatf("seq_code_%0d", i), 32'(bus.dbg_code), 32'(exp_rom[i % 16]));
      check($sformatf("seq_pc_en_off_%0d", i), 32'(bus.dbg_pc_en), 0);
      tick(7);
    end
    check("seq_wrap_pc", 32'(bus.dbg_pc), 1);

    // Tempo 3: step every 32 cycles
    bus.Sw = sw(1'b1, 4'd3, 1'b1, 3'd7);
    tick(31);
    check("tempo3_hold_pc", 32'(bus.dbg_pc), 1);
    check("tempo3_hold_en", 32'(bus.dbg_pc_en), 0);
    tick(1);
    check("tempo3_step_pc", 32'(bus.dbg_pc), 2);
    check("tempo3_step_en", 32'(bus.dbg_pc_en), 1);
    tick(32);
    check("tempo3_step2_pc", 32'(bus.dbg_pc), 3);

    // Leave sequencer: PC back to 0, live button drives code
    bus.Sw = sw(1'b0, 4'd3, 1'b1, 3'd7);
    tick(1);
    check("leave_seq_pc", 32'(bus.dbg_pc), 0);
    check("leave_seq_code", 32'(bus.dbg_code), 1);

    // Reset mid-sequence at PC=9
    bus.Sw = sw(1'b1, 4'd0, 1'b1, 3'd7);
    tick(1);
    tick(71);
    check("seq_pc9", 32'(bus.dbg_pc), 9);
    tick(3);
    check("seq_pc9_code", 32'(bus.dbg_code), 1);
    reset = 1'b0;
    tick(1);
    check("seq_reset_pc", 32'(bus.dbg_pc), 0);
    check("seq_reset_code", 32'(bus.dbg_code), 0);
    check("seq_reset_out", 32'(bus.Output_Sound), 0);
    reset = 1'b1;
    tick(1);
    check("seq_restart_code", 32'(bus.dbg_code), 1);
    check("seq_restart_pc", 32'(bus.dbg_pc), 0);
    tick(7);
    check("seq_restart_step_pc", 32'(bus.dbg_pc), 1);
    check("seq_restart_step_en", 32'(bus.dbg_pc_en), 1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_synth_top.md
Name: cpu_synth_top

Overview:
- Top level of the FPGA synthesizer.
- Converts user input (4 buttons, 10 slide switches) into a 1-bit square-wave audio output.
- Two modes:
  - Live: a button selects the note.
  - Sequencer: a 4-bit program counter (PC) steps through a fixed 16-entry note ROM at a switch-selected tempo.
- Drives the board audio pin directly.

Parameters:
- STEP_CYCLES, 12_500_000, base clock cycles per sequencer step unit (0.25 s at 50 MHz).
- PC_WIDTH, 4, program-counter width; ROM depth is 2**PC_WIDTH.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; one clock; logic resets when reset=0 at a rising edge.
- buttons  input  4  note buttons, active-high, synchronous to clock.
- Sw  input  10  switches:
  - Sw[2:0] octave shift 0..7.
  - Sw[3] output enable (1 = sound).
  - Sw[7:4] tempo.
  - Sw[8] unused.
  - Sw[9] mode (0 live, 1 sequencer).
- Output_Sound  output  1  registered square-wave audio.

Behaviour:
- Reset (reset=0 at a clock edge) clears:
  - Output_Sound=0, PC=0, step timer=0, tone counter=0.
  - Current note code=0 (rest).
- Note codes (3 bits) and half-period in cycles:
  - 0 = rest
  - 1 = C4, 95556
  - 2 = D4, 85131
  - 3 = E4, 75843
  - 4 = F4, 71586
  - 5 = G4, 63776
  - 6 = A4, 56818
  - 7 = C5, 47778
- Effective half-period = table value >> Sw[2:0] (logical shift, 17-bit).
- Live mode (Sw[9]=0):
  - buttons[0..3] map to codes 1, 3, 5, 7.
  - Lowest-index pressed button wins; no button pressed = code 0.
  - PC and step timer are held at 0.
- Sequencer mode (Sw[9]=1):
  - Step timer counts 0 .. (Sw[7:4]+1)*STEP_CYCLES-1.
  - At the terminal count: PC_en pulses for 1 cycle, the timer reloads to 0, and PC increments modulo 2**PC_WIDTH (15 wraps to 0).
  - Code = ROM[PC]. ROM contents, index 0..15: 1,3,5,7,5,3,1,0,1,1,5,5,6,6,5,0.
  - Buttons are ignored.
  - Leaving sequencer mode returns PC to 0 on the next edge.
  - Tempo changes take effect at the next comparison; if the timer is already at or above the new terminal count, it steps on the next cycle.
- Tone generator:
  - Registered note code compared each cycle.
  - On code change or octave change: counter clears to 0 and Output_Sound forces 0.
  - Otherwise the counter increments; when it reaches half-period-1, Output_Sound toggles and the counter clears.
  - Output period = 2 × half-period cycles, 50% duty.
  - Code 0 or Sw[3]=0: counter held at 0, Output_Sound=0.
- Latency: input change to note-code register, 1 cycle; first toggle occurs half-period cycles after the code register updates.
- Reset mid-note: output drops to 0 on that edge; no glitch pulse.

Decomposition:
- Shared package synth_pkg holds:
  - Note code constants.
  - 8-entry half-period table.
  - 16-entry sequence ROM contents.
  - Button-to-code map.
- One sub-module, tone_gen: inputs clock, reset, code, octave, enable; output Output_Sound. It contains the divider and toggle logic.
- Top level holds input registers, mode mux, step timer and PC.

Test Plan:
- Hold reset=0 for 2 cycles with buttons=4'b0001 -> Output_Sound=0, PC=0. Release reset -> no toggle until the first half-period elapses.
- Live mode, Sw[9]=0, Sw[3]=1, Sw[2:0]=7, buttons=4'b0001 -> half-period 746 cycles, period 1492 cycles. Change to buttons=4'b0100 -> G4 half-period 498; output restarts low.
- buttons=4'b1010 -> code 3 (E4, lowest index wins), half-period 75843>>7=592. Set Sw[3]=0 -> Output_Sound stays 0.
- Sequencer mode, STEP_CYCLES=8, Sw[7:4]=0, Sw[9]=1 -> PC_en every 8 cycles; PC runs 0..15 then wraps to 0. Codes follow the ROM order; steps 7 and 15 are silent.
- Sw[7:4]=3 in sequencer mode -> PC step every 32 cycles. Drop Sw[9] to 0 -> PC=0 next cycle.
- Apply reset mid-tone in sequencer mode at PC=9 -> PC=0 and Output_Sound=0 on that edge; sequence restarts from ROM[0] after release.
